imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 138 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: stage 1 decodes the instruction format,
// stage 2 produces the sign/zero-extended immediate behind a valid/ready skid-free pipe.
module imm_gen_pipe #(
  parameter int N        = 64,
  parameter bit SCALE_BR = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] imm,
  output logic [2:0]   fmt
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_B    = 3'd3,
    FMT_I    = 3'd4
  } fmt_e;

  // Stage 1 keeps only the payload bits; the opcode is already folded into s1_fmt.
  logic          s1_valid_q, s1_valid_d;
  logic [25:0]   s1_instr_q, s1_instr_d;
  fmt_e          s1_fmt_q,   s1_fmt_d;

  logic          s2_valid_q, s2_valid_d;
  logic [N-1:0]  s2_imm_q,   s2_imm_d;
  fmt_e          s2_fmt_q,   s2_fmt_d;

  fmt_e          fmt_dec;
  logic          s1_load;
  logic          s2_load;

  logic [N-1:0]  d_ext;
  logic [N-1:0]  cb_ext;
  logic [N-1:0]  b_ext;
  logic [N-1:0]  i_ext;
  logic [N-1:0]  cb_imm;
  logic [N-1:0]  b_imm;
  logic [N-1:0]  imm_sel;

  always_comb begin
    fmt_dec = FMT_NONE;
    if (instr[31:21] == 11'h7C2 || instr[31:21] == 11'h7C0) begin
      fmt_dec = FMT_D;
    end else if (instr[31:24] == 8'hB4 || instr[31:24] == 8'hB5) begin
      fmt_dec = FMT_CB;
    end else if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
      fmt_dec = FMT_B;
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      fmt_dec = FMT_I;
    end
  end

  assign d_ext  = {{(N-9){s1_instr_q[20]}},  s1_instr_q[20:12]};
  assign cb_ext = {{(N-19){s1_instr_q[23]}}, s1_instr_q[23:5]};
  assign b_ext  = {{(N-26){s1_instr_q[25]}}, s1_instr_q[25:0]};
  assign i_ext  = {{(N-12){1'b0}},           s1_instr_q[21:10]};

  // Branch offsets are word counts; scaling converts them to byte offsets.
  generate
    if (SCALE_BR) begin : g_scale
      assign cb_imm = cb_ext << 2;
      assign b_imm  = b_ext << 2;
    end else begin : g_noscale
      assign cb_imm = cb_ext;
      assign b_imm  = b_ext;
    end
  endgenerate

  always_comb begin
    imm_sel = '0;
    unique case (s1_fmt_q)
      FMT_D:   imm_sel = d_ext;
      FMT_CB:  imm_sel = cb_imm;
      FMT_B:   imm_sel = b_imm;
      FMT_I:   imm_sel = i_ext;
      default: imm_sel = '0;
    endcase
  end

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_fmt_d   = s2_fmt_q;

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_d = imm_sel;
        s2_fmt_d = s1_fmt_q;
      end
    end

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_instr_d = instr[25:0];
        s1_fmt_d   = fmt_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_fmt_q   <= FMT_NONE;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_fmt_q   <= FMT_NONE;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_fmt_q   <= s2_fmt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign imm       = s2_imm_q;
  assign fmt       = s2_fmt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: two instances (N=64 scaled, N=32 unscaled) share one stimulus
// stream and are compared against an arithmetic reference model and an in-flight queue.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        in_ready,  out_valid;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.N(64), .SCALE_BR(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .fmt(fmt)
  );

  imm_gen_pipe #(.N(32), .SCALE_BR(1'b0)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .out_valid(out_valid32), .out_ready(out_ready),
    .imm(imm32), .fmt(fmt32)
  );

  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic [2:0]  f;
    int          acc;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] d_ins [6] = '{32'hF8402000, 32'hF8580000, 32'hB4800252,
                             32'h17FFFFFF, 32'h913FFC00, 32'h8B000000};
  logic [63:0] d_e64 [6] = '{64'h2, 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFF0_0048,
                             64'hFFFF_FFFF_FFFF_FFFC, 64'h0FFF, 64'h0};
  logic [31:0] d_e32 [6] = '{32'h2, 32'hFFFF_FF80, 32'hFFFC_0012,
                             32'hFFFF_FFFF, 32'h0FFF, 32'h0};
  logic [2:0]  d_f   [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  function automatic logic [2:0] ref_fmt(input logic [31:0] w);
    if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) return 3'd1;
    if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5) return 3'd2;
    if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) return 3'd3;
    if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) return 3'd4;
    return 3'd0;
  endfunction

  // Integer value of the immediate, then two's-complement truncation to n bits.
  function automatic logic [127:0] ref_imm(input logic [31:0] w, input int n, input bit scale);
    longint v;
    logic [127:0] r;
    logic [127:0] mask;
    v = 0;
    case (ref_fmt(w))
      3'd1: begin v = longint'(w[20:12]); if (v >= 256) v = v - 512; end
      3'd2: begin v = longint'(w[23:5]); if (v >= (1 << 18)) v = v - (1 << 19); if (scale) v = v * 4; end
      3'd3: begin v = longint'(w[25:0]); if (v >= (1 << 25)) v = v - (1 << 26); if (scale) v = v * 4; end
      3'd4: v = longint'(w[21:10]);
      default: v = 0;
    endcase
    r    = {{64{v[63]}}, v};
    mask = ~(~128'd0 << n);
    return r & mask;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[31:21] = ($urandom_range(0, 1) != 0) ? 11'h7C2 : 11'h7C0;
      1: w[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB4 : 8'hB5;
      2: w[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101;
      3: w[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock of stimulus; when lit is set the literal beat overrides the model.
  task automatic step(input bit v, input logic [31:0] w, input bit ordy,
                      input bit lit, input beat_t lb, output bit acc);
    beat_t b;
    logic [127:0] t;
    bit exp_ov, exp_rdy;
    in_valid  = v;
    instr     = w;
    out_ready = ordy;
    #1;
    exp_ov  = (q.size() > 0) && (q[0].acc <= cyc - 2);
    exp_rdy = !(q.size() == 2 && !ordy);
    chk("out_valid",   out_valid,   exp_ov);
    chk("out_valid32", out_valid32, exp_ov);
    chk("in_ready",    in_ready,    exp_rdy);
    chk("in_ready32",  in_ready32,  exp_rdy);
    if (exp_ov) begin
      chk("imm64", imm,   q[0].i64);
      chk("imm32", imm32, q[0].i32);
      chk("fmt64", fmt,   q[0].f);
      chk("fmt32", fmt32, q[0].f);
      if (ordy) begin
        $display("cyc %0d out  fmt=%0d imm64=%h imm32=%h", cyc, q[0].f, q[0].i64, q[0].i32);
        void'(q.pop_front());
      end
    end
    acc = v && exp_rdy;
    if (acc) begin
      if (lit) begin
        b = lb;
      end else begin
        b.f = ref_fmt(w);
        t = ref_imm(w, 64, 1'b1);
        b.i64 = t[63:0];
        t = ref_imm(w, 32, 1'b0);
        b.i32 = t[31:0];
      end
      b.acc = cyc;
      q.push_back(b);
      $display("cyc %0d in   instr=%h", cyc, w);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    instr     = rand_instr();
    out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("rst_out_valid",   out_valid,   1'b0);
    chk("rst_out_valid32", out_valid32, 1'b0);
    chk("rst_imm64",       imm,         64'h0);
    chk("rst_imm32",       imm32,       32'h0);
    chk("rst_fmt",         fmt,         3'd0);
    chk("rst_in_ready",    in_ready,    1'b1);
    chk("rst_in_ready32",  in_ready32,  1'b1);
    $display("cyc %0d reset", cyc);
  endtask

  initial begin
    beat_t nb;
    beat_t lb;
    bit acc;
    int sent;
    logic [31:0] w;
    nb.i64 = '0; nb.i32 = '0; nb.f = '0; nb.acc = 0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed vectors with known answers, back-to-back.
    for (int i = 0; i < 6; i++) begin
      lb.i64 = d_e64[i]; lb.i32 = d_e32[i]; lb.f = d_f[i]; lb.acc = 0;
      step(1'b1, d_ins[i], 1'b1, 1'b1, lb, acc);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, nb, acc);

    // Fill and stall: in_ready must drop once both stages hold a beat.
    for (int i = 0; i < 4; i++) step(1'b1, rand_instr(), 1'b0, 1'b0, nb, acc);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b0, 1'b0, nb, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, nb, acc);

    // Eight back-to-back beats with random downstream readiness.
    sent = 0;
    w = rand_instr();
    for (int i = 0; i < 64 && sent < 8; i++) begin
      step(1'b1, w, $urandom_range(0, 1) != 0, 1'b0, nb, acc);
      if (acc) begin
        sent++;
        w = rand_instr();
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, nb, acc);

    // Random traffic on both sides.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0, 1'b0, nb, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, nb, acc);

    // Reset with two beats in flight: neither may ever appear.
    step(1'b1, rand_instr(), 1'b0, 1'b0, nb, acc);
    step(1'b1, rand_instr(), 1'b0, 1'b0, nb, acc);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, nb, acc);

    // Recovery after reset.
    lb.i64 = d_e64[2]; lb.i32 = d_e32[2]; lb.f = d_f[2]; lb.acc = 0;
    step(1'b1, d_ins[2], 1'b1, 1'b1, lb, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, nb, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
